adder_serial: RTL and testbench

- Bit-serial N-bit adder that sits directly downstream of the half-adder cell. It consumes the cell's sum/carry outputs one bit per clock.
- A full-adder slice is built from two adder_half instances plus an OR, closed around a carry flip-flop.
- Operands are loaded in parallel and processed LSB-first over WIDTH cycles. The block returns a parallel sum and carry-out with a start/busy/done handshake.
- Serves as the area-minimal adder for wide operands in the arithmetic datapath.

---
 rtl/adder_serial.sv | 140 ++++++++++++++
 tb/tb_adder_serial.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_serial.sv
// ============================================================================
// Module   : adder_serial
// Brief    : Bit-serial WIDTH-bit adder, LSB-first, one full-adder slice built
//            from two half-adder cells plus a carry flip-flop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_half (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module adder_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   r_sh_q, r_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d;
  logic               cout_q, cout_d;

  logic s1, c1, s_bit, c2, c_next;

  adder_half u_ha1 (
    .x_i (a_sh_q[0]),
    .y_i (b_sh_q[0]),
    .s_o (s1),
    .c_o (c1)
  );

  adder_half u_ha2 (
    .x_i (s1),
    .y_i (c_q),
    .s_o (s_bit),
    .c_o (c2)
  );

  assign c_next = c1 | c2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_sh_d = {s_bit, r_sh_q[WIDTH-1:1]};
        c_d    = c_next;
        cnt_d  = cnt_q + 1'b1;
        // Last bit: the result register is complete only after this shift.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {s_bit, r_sh_q[WIDTH-1:1]};
          cout_d  = c_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_serial.sv
// ============================================================================
// Module   : tb_adder_serial
// Brief    : Scoreboard-driven bench for the bit-serial adder (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_serial;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic [8:0] exp_q[$];
  int         pass_cnt;
  int         total_cnt;

  adder_serial #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Drive one start in the next cycle and record its expected result.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
    @(negedge clk);
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    exp_q.push_back({1'b0, ia} + {1'b0, ib} + {8'd0, ic});
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom);
  endtask

  // Wait (bounded) for done; n is the cycle index after the start edge, 0 on timeout.
  task automatic wait_done(output int n, output int nbusy, output bit stable);
    logic [8:0] held;
    held   = {cout, sum};
    n      = 0;
    nbusy  = 0;
    stable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
      if (busy) nbusy++;
      if ({cout, sum} !== held) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({busy, done, cout, sum} !== 11'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, required all zero",
               busy, done, cout, sum);
    else pass_cnt++;
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_idle: got busy=%b done=%b, required 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int n, nb;
    bit st;
    logic [8:0] e;
    issue(8'h3C, 8'h45, 1'b0);
    wait_done(n, nb, st);
    total_cnt++;
    if (n !== 9) $display("FAIL basic_done_latency: got %0d, required 9", n);
    else pass_cnt++;
    total_cnt++;
    if (nb !== 8) $display("FAIL basic_busy_cycles: got %0d, required 8", nb);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if ({cout, sum} !== e || e !== 9'h081)
      $display("FAIL basic_result: got cout=%b sum=%h, required cout=0 sum=81", cout, sum);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse_width: got done=%b, required 0", done);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    int n, nb;
    bit st;
    logic [8:0] e;
    issue(8'hFF, 8'h01, 1'b0);
    wait_done(n, nb, st);
    e = exp_q.pop_front();
    total_cnt++;
    if (n == 0 || {cout, sum} !== e)
      $display("FAIL carry_ripple: got n=%0d cout=%b sum=%h, required cout=%b sum=%h",
               n, cout, sum, e[8], e[7:0]);
    else pass_cnt++;
  endtask

  task automatic test_full();
    int n, nb;
    bit st;
    logic [8:0] e;
    logic [16:0] vec[2];
    vec[0] = {8'hFF, 8'hFF, 1'b1};
    vec[1] = {8'h00, 8'h00, 1'b1};
    for (int k = 0; k < 2; k++) begin
      issue(vec[k][16:9], vec[k][8:1], vec[k][0]);
      wait_done(n, nb, st);
      e = exp_q.pop_front();
      total_cnt++;
      if (n == 0 || {cout, sum} !== e)
        $display("FAIL full_case_%0d: got cout=%b sum=%h, required cout=%b sum=%h",
                 k, cout, sum, e[8], e[7:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored();
    int n, nb, ndone, nbusy_after;
    logic [8:0] e;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    exp_q.push_back(9'h030);
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    nb = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
      if (busy) nb++;
      start = (i == 3);
      a = 8'hAA;
      b = 8'h55;
    end
    start = 1'b1;
    total_cnt++;
    if (n !== 9) $display("FAIL ignore_done_latency: got %0d, required 9", n);
    else pass_cnt++;
    total_cnt++;
    if (nb !== 8) $display("FAIL ignore_busy_cycles: got %0d, required 8", nb);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if ({cout, sum} !== e)
      $display("FAIL ignore_result: got cout=%b sum=%h, required cout=0 sum=30", cout, sum);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    nbusy_after = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) ndone++;
      if (busy) nbusy_after++;
      @(negedge clk);
    end
    total_cnt++;
    if (ndone !== 0 || nbusy_after !== 0)
      $display("FAIL ignore_no_second_op: got done=%0d busy=%0d cycles, required 0 0",
               ndone, nbusy_after);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    int n, nb, ndone;
    bit st;
    logic [8:0] e;
    issue(8'h3C, 8'h45, 1'b0);
    wait_done(n, nb, st);
    e = exp_q.pop_front();
    total_cnt++;
    if ({cout, sum} !== e)
      $display("FAIL midop_pre_result: got sum=%h, required %h", sum, e[7:0]);
    else pass_cnt++;
    issue(8'h7F, 8'h01, 1'b0);
    repeat (4) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL midop_busy_before_rst: got %b, required 1", busy);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    total_cnt++;
    if ({busy, done, cout, sum} !== 11'd0)
      $display("FAIL midop_abort: got busy=%b done=%b cout=%b sum=%h, required all zero",
               busy, done, cout, sum);
    else pass_cnt++;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total_cnt++;
    if (ndone !== 0) $display("FAIL midop_no_done: got %0d pulses, required 0", ndone);
    else pass_cnt++;
    issue(8'h01, 8'h02, 1'b0);
    wait_done(n, nb, st);
    e = exp_q.pop_front();
    total_cnt++;
    if (n == 0 || {cout, sum} !== e)
      $display("FAIL midop_restart: got cout=%b sum=%h, required cout=0 sum=03", cout, sum);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n, nb;
    bit st;
    logic [8:0] e;
    for (int k = 0; k < 8; k++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done(n, nb, st);
      total_cnt++;
      if (n !== 9) $display("FAIL b2b_latency_%0d: got %0d, required 9", k, n);
      else pass_cnt++;
      total_cnt++;
      if (st !== 1'b1) $display("FAIL b2b_hold_%0d: got unstable sum/cout, required stable", k);
      else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++;
      if ({cout, sum} !== e)
        $display("FAIL b2b_result_%0d: got cout=%b sum=%h, required cout=%b sum=%h",
                 k, cout, sum, e[8], e[7:0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_full();
    test_start_ignored();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
